// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_unit
// Purpose  : EX operand forwarding select, long-latency register scoreboard,
//            load-use / scoreboard hazard detection and ID stall generation.
// Option   : define HAZARD_PERF_CNT_EN to build the saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit #(
  parameter int NREGS   = 32,
  parameter int NRPORTS = 2,
  parameter int MAX_LL  = 4,
  localparam int REG_W  = $clog2(NREGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_flush,
  input  logic                     i_ID_valid,
  input  logic [NRPORTS*REG_W-1:0] i_ID_rnum,
  input  logic [NRPORTS-1:0]       i_ID_ren,
  input  logic [REG_W-1:0]         i_ID_wnum,
  input  logic                     i_ID_wen,
  input  logic                     i_ID_long,
  input  logic [NRPORTS*REG_W-1:0] i_EX_rnum,
  input  logic [REG_W-1:0]         i_EX_wnum,
  input  logic                     i_EX_wen,
  input  logic                     i_EX_load,
  input  logic [REG_W-1:0]         i_MEM_wnum,
  input  logic                     i_MEM_wen,
  input  logic [REG_W-1:0]         i_WB_wnum,
  input  logic                     i_WB_wen,
  input  logic                     i_LL_done,
  input  logic [REG_W-1:0]         i_LL_wnum,
  output logic [NRPORTS*2-1:0]     o_fwd_sel,
  output logic                     o_stall,
  output logic                     o_sb_full,
  output logic                     o_sb_err,
  output logic [31:0]              o_stall_cnt
);

  localparam int CNT_W = $clog2(MAX_LL + 1);

  logic [NREGS-1:0] pend_q, pend_d, w_pend_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d, w_cnt_eff;
  logic             sb_err_q, sb_err_d;
  logic             sb_full_q, sb_full_d;
  logic             w_comp, w_loaduse, w_raw, w_waw, w_full, w_stall, w_issue;
  logic             w_long_wr;

  always_comb begin
    o_fwd_sel = '0;
    for (int p = 0; p < NRPORTS; p++) begin
      if (i_MEM_wen && i_MEM_wnum != '0 && i_MEM_wnum == i_EX_rnum[p*REG_W +: REG_W])
        o_fwd_sel[p*2 +: 2] = 2'b10;
      else if (i_WB_wen && i_WB_wnum != '0 && i_WB_wnum == i_EX_rnum[p*REG_W +: REG_W])
        o_fwd_sel[p*2 +: 2] = 2'b01;
    end
  end

  // A completion landing this cycle hides its register from the hazard checks.
  always_comb begin
    w_pend_eff = pend_q;
    w_comp     = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (i_LL_done && i_LL_wnum == REG_W'(r)) begin
        w_pend_eff[r] = 1'b0;
        w_comp        = pend_q[r];
      end
    end
  end

  assign w_long_wr = i_ID_long && i_ID_wen && i_ID_wnum != '0;
  assign w_cnt_eff = cnt_q - CNT_W'(w_comp);

  always_comb begin
    w_loaduse = 1'b0;
    w_raw     = 1'b0;
    w_waw     = 1'b0;
    for (int p = 0; p < NRPORTS; p++) begin
      if (i_ID_ren[p] && i_EX_load && i_EX_wen && i_EX_wnum != '0 &&
          i_ID_rnum[p*REG_W +: REG_W] == i_EX_wnum)
        w_loaduse = 1'b1;
      for (int r = 0; r < NREGS; r++) begin
        if (i_ID_ren[p] && i_ID_rnum[p*REG_W +: REG_W] == REG_W'(r) && w_pend_eff[r])
          w_raw = 1'b1;
      end
    end
    for (int r = 1; r < NREGS; r++) begin
      if (i_ID_wen && i_ID_wnum == REG_W'(r) && w_pend_eff[r])
        w_waw = 1'b1;
    end
  end

  assign w_full  = w_long_wr && (w_cnt_eff == CNT_W'(MAX_LL));
  assign w_stall = i_ID_valid && !i_flush && (w_loaduse || w_raw || w_waw || w_full);
  assign w_issue = i_ID_valid && w_long_wr && !w_stall && !i_flush;
  assign o_stall = w_stall;

  // Set after clear so a same-cycle issue and completion leave the bit set.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREGS; r++) begin
      if (w_comp && i_LL_wnum == REG_W'(r))
        pend_d[r] = 1'b0;
      if (w_issue && i_ID_wnum == REG_W'(r))
        pend_d[r] = 1'b1;
    end
    cnt_d     = cnt_q + CNT_W'(w_issue) - CNT_W'(w_comp);
    sb_full_d = (cnt_d == CNT_W'(MAX_LL));
    sb_err_d  = sb_err_q || (i_LL_done && !w_comp);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_q    <= '0;
      cnt_q     <= '0;
      sb_err_q  <= 1'b0;
      sb_full_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      sb_err_q  <= sb_err_d;
      sb_full_q <= sb_full_d;
    end
  end

  assign o_sb_full = sb_full_q;
  assign o_sb_err  = sb_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = (w_stall && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1
                                                                  : stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard_unit
// Purpose  : directed + randomized check of hazard_scoreboard_unit against a
//            set-based reference model of the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_unit;
  localparam int NREGS = 32, NRPORTS = 2, MAX_LL = 4, REG_W = 5;

  logic i_clk = 1'b0, i_rstn = 1'b0;
  logic i_flush, i_ID_valid, i_ID_wen, i_ID_long, i_EX_wen, i_EX_load;
  logic i_MEM_wen, i_WB_wen, i_LL_done;
  logic [NRPORTS*REG_W-1:0] i_ID_rnum, i_EX_rnum;
  logic [NRPORTS-1:0] i_ID_ren;
  logic [REG_W-1:0] i_ID_wnum, i_EX_wnum, i_MEM_wnum, i_WB_wnum, i_LL_wnum;
  logic [NRPORTS*2-1:0] o_fwd_sel;
  logic o_stall, o_sb_full, o_sb_err;
  logic [31:0] o_stall_cnt;

  hazard_scoreboard_unit #(.NREGS(NREGS), .NRPORTS(NRPORTS), .MAX_LL(MAX_LL)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush), .i_ID_valid(i_ID_valid),
    .i_ID_rnum(i_ID_rnum), .i_ID_ren(i_ID_ren), .i_ID_wnum(i_ID_wnum),
    .i_ID_wen(i_ID_wen), .i_ID_long(i_ID_long), .i_EX_rnum(i_EX_rnum),
    .i_EX_wnum(i_EX_wnum), .i_EX_wen(i_EX_wen), .i_EX_load(i_EX_load),
    .i_MEM_wnum(i_MEM_wnum), .i_MEM_wen(i_MEM_wen), .i_WB_wnum(i_WB_wnum),
    .i_WB_wen(i_WB_wen), .i_LL_done(i_LL_done), .i_LL_wnum(i_LL_wnum),
    .o_fwd_sel(o_fwd_sel), .o_stall(o_stall), .o_sb_full(o_sb_full),
    .o_sb_err(o_sb_err), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_err = 0;
  bit pend_m [NREGS];
  bit err_m;
  int unsigned sc_m;
  logic [3:0] last_fwd;
  logic last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int outstanding();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(pend_m[r]);
    return n;
  endfunction

  function automatic bit visible(input int r);
    return pend_m[r] && !(i_LL_done && int'(i_LL_wnum) == r);
  endfunction

  function automatic logic [31:0] exp_sc();
`ifdef HAZARD_PERF_CNT_EN
    return sc_m;
`else
    return 32'd0;
`endif
  endfunction

  function automatic int src(input logic [NRPORTS*REG_W-1:0] v, input int p);
    return int'(v[p*REG_W +: REG_W]);
  endfunction

  task automatic model_reset();
    foreach (pend_m[r]) pend_m[r] = 1'b0;
    err_m = 1'b0;
    sc_m  = 0;
  endtask

  task automatic idle();
    i_flush = 0; i_ID_valid = 0; i_ID_rnum = '0; i_ID_ren = '0; i_ID_wnum = '0;
    i_ID_wen = 0; i_ID_long = 0; i_EX_rnum = '0; i_EX_wnum = '0; i_EX_wen = 0;
    i_EX_load = 0; i_MEM_wnum = '0; i_MEM_wen = 0; i_WB_wnum = '0; i_WB_wen = 0;
    i_LL_done = 0; i_LL_wnum = '0;
  endtask

  // Inputs are already driven; check combinational outputs, clock, check state.
  task automatic step();
    logic [3:0] efwd;
    bit hz, st, iss, comp;
    int dst, ll;
    #1;
    efwd = '0;
    hz   = 1'b0;
    dst  = int'(i_ID_wnum);
    ll   = int'(i_LL_wnum);
    for (int p = 0; p < NRPORTS; p++) begin
      if (i_MEM_wen && i_MEM_wnum != 0 && int'(i_MEM_wnum) == src(i_EX_rnum, p))
        efwd[p*2 +: 2] = 2'b10;
      else if (i_WB_wen && i_WB_wnum != 0 && int'(i_WB_wnum) == src(i_EX_rnum, p))
        efwd[p*2 +: 2] = 2'b01;
      if (i_ID_ren[p] && visible(src(i_ID_rnum, p))) hz = 1;
      if (i_ID_ren[p] && i_EX_load && i_EX_wen && i_EX_wnum != 0 &&
          src(i_ID_rnum, p) == int'(i_EX_wnum)) hz = 1;
    end
    if (i_ID_wen && dst != 0 && visible(dst)) hz = 1;
    comp = i_LL_done && pend_m[ll];
    if (i_ID_long && i_ID_wen && dst != 0 && outstanding() - int'(comp) == MAX_LL) hz = 1;
    st  = i_ID_valid && hz && !i_flush;
    iss = i_ID_valid && i_ID_long && i_ID_wen && dst != 0 && !st && !i_flush;
    chk("fwd_sel", 32'(o_fwd_sel), 32'(efwd));
    chk("stall", 32'(o_stall), 32'(st));
    last_fwd   = o_fwd_sel;
    last_stall = o_stall;
    @(posedge i_clk);
    if (i_LL_done && !comp) err_m = 1;
    if (comp) pend_m[ll] = 0;
    if (iss) pend_m[dst] = 1;
    if (st) sc_m++;
    #1;
    chk("sb_full", 32'(o_sb_full), 32'(outstanding() == MAX_LL));
    chk("sb_err", 32'(o_sb_err), 32'(err_m));
    chk("stall_cnt", o_stall_cnt, exp_sc());
  endtask

  task automatic issue_long(input int r);
    idle();
    i_ID_valid = 1; i_ID_long = 1; i_ID_wen = 1; i_ID_wnum = REG_W'(r);
    step();
  endtask

  int unsigned sc_base;
  int pick;

  initial begin
    idle();
    model_reset();
    #12 i_rstn = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_full", 32'(o_sb_full), 0);
    chk("rst_err", 32'(o_sb_err), 0);
    chk("rst_scnt", o_stall_cnt, 0);

    // Forwarding priority
    idle();
    i_EX_rnum = {5'd5, 5'd5}; i_MEM_wen = 1; i_MEM_wnum = 5; i_WB_wen = 1; i_WB_wnum = 5;
    step(); chk("fwd_mem", 32'(last_fwd), 32'b1010);
    i_MEM_wnum = 0;
    step(); chk("fwd_wb", 32'(last_fwd), 32'b0101);
    i_MEM_wen = 0; i_WB_wen = 0; i_MEM_wnum = 5;
    step(); chk("fwd_rf", 32'(last_fwd), 0);

    // Load-use then bubble
    idle();
    i_EX_load = 1; i_EX_wen = 1; i_EX_wnum = 7;
    i_ID_valid = 1; i_ID_ren = 2'b10; i_ID_rnum = {5'd7, 5'd3};
    step(); chk("lu_stall", 32'(last_stall), 1);
    i_EX_load = 0; i_EX_wen = 0;
    step(); chk("lu_bubble", 32'(last_stall), 0);

    // Scoreboard RAW with same-cycle completion bypass
    issue_long(9);
    idle();
    i_ID_valid = 1; i_ID_ren = 2'b01; i_ID_rnum = {5'd0, 5'd9};
    step(); chk("raw_stall", 32'(last_stall), 1);
    step(); chk("raw_hold", 32'(last_stall), 1);
    i_LL_done = 1; i_LL_wnum = 9;
    step(); chk("raw_bypass", 32'(last_stall), 0);
    i_LL_done = 0;
    step(); chk("raw_clear", 32'(last_stall), 0);

    // Full
    for (int r = 1; r <= 4; r++) issue_long(r);
    chk("full_set", 32'(o_sb_full), 1);
    idle();
    i_ID_valid = 1; i_ID_long = 1; i_ID_wen = 1; i_ID_wnum = 5;
    step(); chk("full_stall", 32'(last_stall), 1);
    i_LL_done = 1; i_LL_wnum = 2;
    step(); chk("full_swap", 32'(last_stall), 0);
    chk("full_keep", 32'(o_sb_full), 1);

    // Spurious completion
    idle();
    i_LL_done = 1; i_LL_wnum = 12;
    step(); chk("err_set", 32'(o_sb_err), 1);
    chk("err_cnt", 32'(o_sb_full), 1);

    // Asynchronous reset mid-cycle
    idle();
    @(posedge i_clk); #3 i_rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_full", 32'(o_sb_full), 0);
    chk("arst_err", 32'(o_sb_err), 0);
    chk("arst_scnt", o_stall_cnt, 0);
    #2 i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // Three stall cycles for the perf counter
    sc_base = o_stall_cnt;
    idle();
    i_EX_load = 1; i_EX_wen = 1; i_EX_wnum = 4;
    i_ID_valid = 1; i_ID_ren = 2'b01; i_ID_rnum = {5'd0, 5'd4};
    repeat (3) step();
`ifdef HAZARD_PERF_CNT_EN
    chk("perf3", o_stall_cnt - sc_base, 3);
`else
    chk("perf3", o_stall_cnt - sc_base, 0);
`endif

    // Randomized traffic over a small register window to force collisions
    for (int i = 0; i < 400; i++) begin
      i_flush    = ($urandom_range(0, 7) == 0);
      i_ID_valid = ($urandom_range(0, 3) != 0);
      i_ID_rnum  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      i_ID_ren   = 2'($urandom);
      i_ID_wnum  = 5'($urandom_range(0, 7));
      i_ID_wen   = ($urandom_range(0, 3) != 0);
      i_ID_long  = ($urandom_range(0, 1) != 0);
      i_EX_rnum  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      i_EX_wnum  = 5'($urandom_range(0, 7));
      i_EX_wen   = 1'($urandom);
      i_EX_load  = ($urandom_range(0, 3) == 0);
      i_MEM_wnum = 5'($urandom_range(0, 7));
      i_MEM_wen  = 1'($urandom);
      i_WB_wnum  = 5'($urandom_range(0, 7));
      i_WB_wen   = 1'($urandom);
      pick       = $urandom_range(0, 7);
      i_LL_wnum  = 5'(pick);
      i_LL_done  = pend_m[pick] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised successor to the pipeline forwarding logic. It combines per-port operand forwarding selection for EX with a register scoreboard for long-latency results (loads that miss, divides). It also detects load-use and scoreboard hazards and drives the ID stall. It sits between the decode/issue stage and the EX operand muxes of the core.

## Interface
Parameters:
- NREGS, 32, architectural register count; REG_W = $clog2(NREGS).
- NRPORTS, 2, source-operand read ports per instruction.
- MAX_LL, 4, maximum long-latency writes outstanding at once (1..NREGS-1).

Ports:
- Clock and reset: one clock, `i_clk`; reset is asynchronous and active-low, `i_rstn`.
- i_flush  in  1  squash the instruction currently in ID; no issue.
- i_ID_valid  in  1  valid instruction in ID.
- i_ID_rnum  in  NRPORTS*REG_W  ID source registers, port p at [p*REG_W +: REG_W].
- i_ID_ren  in  NRPORTS  per-port source-used flag.
- i_ID_wnum  in  REG_W  ID destination register.
- i_ID_wen  in  1  ID instruction writes a register.
- i_ID_long  in  1  ID instruction is long-latency (completes via LL port).
- i_EX_rnum  in  NRPORTS*REG_W  EX source registers, same packing.
- i_EX_wnum  in  REG_W  EX destination.
- i_EX_wen  in  1  EX writes a register.
- i_EX_load  in  1  EX instruction is a short load.
- i_MEM_wnum  in  REG_W  MEM destination.
- i_MEM_wen  in  1  MEM writes a register.
- i_WB_wnum  in  REG_W  WB destination.
- i_WB_wen  in  1  WB writes a register.
- i_LL_done  in  1  long-latency unit writes back this cycle.
- i_LL_wnum  in  REG_W  register completed by the LL unit.
- o_fwd_sel  out  NRPORTS*2  per-port EX operand select: 2'b10 MEM, 2'b01 WB, 2'b00 register file.
- o_stall  out  1  hold PC/IF/ID, insert bubble in EX.
- o_sb_full  out  1  MAX_LL writes outstanding.
- o_sb_err  out  1  sticky: LL completion for a non-pending register.
- o_stall_cnt  out  32  stall-cycle counter (see Configuration).

## Operation
- Forwarding is evaluated per port p, independently:
  - MEM match (i_MEM_wen, i_MEM_wnum != 0, equal to EX rnum[p]) selects 2'b10 and has priority.
  - Otherwise a WB match under the same rules selects 2'b01.
  - Otherwise the select is 2'b00.
- Scoreboard: `pend[NREGS]` holds one bit per register; bit 0 is never set. `cnt` holds the number of set bits.
- Effective pending bit: `pend_eff[r] = pend[r] & ~(i_LL_done & i_LL_wnum == r)`. A completion in the same cycle bypasses the hazard.
- Hazards are evaluated only when i_ID_valid is high:
  - Load-use: i_EX_load & i_EX_wen & i_EX_wnum != 0 & any used port p with rnum[p] == i_EX_wnum.
  - RAW-LL: any used port p with pend_eff[rnum[p]].
  - WAW-LL: i_ID_wen & i_ID_wnum != 0 & pend_eff[i_ID_wnum].
  - Full: i_ID_long & i_ID_wen & i_ID_wnum != 0 & (cnt - completion_this_cycle) == MAX_LL.
- o_stall is the OR of the four hazards. When i_flush is high, o_stall = 0.
- Issue = i_ID_valid & i_ID_long & i_ID_wen & i_ID_wnum != 0 & ~o_stall & ~i_flush. On issue, the next state sets pend[i_ID_wnum].
- Completion = i_LL_done & pend[i_LL_wnum]. On completion, the next state clears pend[i_LL_wnum].
- Issue and completion to the same register in the same cycle leave the bit set.
- cnt next = cnt + issue - completion. The counter never wraps.
- i_LL_done with a non-pending register, or with register 0, is ignored and sets o_sb_err until reset.
- o_sb_full = (cnt == MAX_LL).

## Timing
- o_fwd_sel and o_stall are combinational, valid in the same cycle as their inputs.
- pend, cnt, o_sb_err, o_sb_full and o_stall_cnt are registered on the rising edge of i_clk. An issue is visible as a hazard from the next cycle.
- Completion has zero-cycle visibility through pend_eff.
- Reset (asynchronous, i_rstn low, any time including mid-operation):
  - pend = 0, cnt = 0, o_sb_err = 0, o_sb_full = 0, o_stall_cnt = 0.
  - The combinational outputs follow their inputs.
- The LL unit is flushed by its own reset; no in-flight state survives.

## Configuration
- Macro `HAZARD_PERF_CNT_EN`.
  - When defined: o_stall_cnt increments on each cycle with o_stall = 1 and saturates at 32'hFFFF_FFFF.
  - When undefined: o_stall_cnt is tied to 0 and no counter flops are built. The port is present in both builds.

## Test plan
- Forwarding priority: EX rnum = {5,5}; MEM wen, wnum 5; WB wen, wnum 5 -> o_fwd_sel = {2'b10, 2'b10}. With MEM wnum 0 -> {2'b01, 2'b01}. With both wen low -> 0.
- Load-use: EX load writes x7; ID valid reads x7 on port 1 -> o_stall = 1 for that cycle. Next cycle, EX is a bubble -> o_stall = 0.
- Scoreboard RAW and bypass:
  - Issue long to x9, then ID reads x9 -> stall held.
  - i_LL_done with x9 in the same cycle -> o_stall = 0 that cycle; pend[9] = 0 and cnt = 0 after the edge.
- Full, with MAX_LL = 4:
  - Issue long to x1..x4 -> o_sb_full = 1.
  - A fifth long to x5 -> stall.
  - A simultaneous completion of x2 -> the issue is accepted and cnt stays 4.
- Error and reset:
  - i_LL_done x12 while not pending -> o_sb_err = 1 and cnt unchanged.
  - Assert i_rstn low mid-cycle -> all registered outputs are 0 immediately.
- Perf counter: stall for 3 cycles -> o_stall_cnt = 3 with HAZARD_PERF_CNT_EN defined, and 0 without it.
